// File: rtl/gate_exerciser.sv
// Self-running sweep of a 2-input gate: drives every {a,b} vector,
// samples the gate output after a settle time and scores it against TRUTH.
module gate_exerciser #(
    parameter logic [3:0]  TRUTH  = 4'b0111,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned PASSES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       s_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    localparam logic [7:0] CNT_LOAD  = 8'(SETTLE);
    localparam logic [3:0] LAST_PASS = 4'(PASSES - 1);
    localparam state_t     FIRST     = (SETTLE == 0) ? SAMPLE : WAIT;

    state_t     state_q;
    logic [1:0] vec_q;
    logic [7:0] cnt_q;
    logic [3:0] pass_cnt_q;

    logic       mismatch;
    logic [3:0] err_d;
    logic [3:0] fail_d;
    logic [1:0] vec_d;
    logic       last_d;

    always_comb begin
        mismatch = (s_in != TRUTH[vec_q]);
        err_d    = err_count;
        fail_d   = fail_vec;
        if (mismatch) begin
            fail_d = fail_vec | (4'd1 << vec_q);
            if (err_count != 4'd15)
                err_d = err_count + 4'd1;
        end
        vec_d  = vec_q + 2'd1;
        last_d = (vec_q == 2'd3) && (pass_cnt_q == LAST_PASS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            vec_q      <= 2'd0;
            cnt_q      <= 8'd0;
            pass_cnt_q <= 4'd0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 4'd0;
            fail_vec   <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vec_q      <= 2'd0;
                        pass_cnt_q <= 4'd0;
                        a_out      <= 1'b0;
                        b_out      <= 1'b0;
                        cnt_q      <= CNT_LOAD;
                        err_count  <= 4'd0;
                        fail_vec   <= 4'd0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state_q    <= FIRST;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1)
                        state_q <= SAMPLE;
                end
                SAMPLE: begin
                    err_count <= err_d;
                    fail_vec  <= fail_d;
                    if (last_d) begin
                        // pass must reflect the final sample too
                        pass    <= (err_d == 4'd0);
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        vec_q <= vec_d;
                        if (vec_q == 2'd3)
                            pass_cnt_q <= pass_cnt_q + 4'd1;
                        {a_out, b_out} <= vec_d;
                        cnt_q   <= CNT_LOAD;
                        state_q <= FIRST;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: three instances cover default,
// multi-pass saturation and zero-settle configurations.
module tb_gate_exerciser;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] start = 3'b000;
    int         mode [3];
    wire  [2:0] a_w, b_w, s_w, busy_w, done_w, pass_w;
    wire  [3:0] err_w  [3];
    wire  [3:0] fail_w [3];

    int checks = 0;
    int errors = 0;
    logic [1:0] trace [0:255];

    // gate models: 0 nand, 1 and, 2 tied high
    function automatic logic model(input int m, input logic a, input logic b);
        case (m)
            0: return ~(a & b);
            1: return a & b;
            default: return 1'b1;
        endcase
    endfunction

    assign s_w[0] = model(mode[0], a_w[0], b_w[0]);
    assign s_w[1] = model(mode[1], a_w[1], b_w[1]);
    assign s_w[2] = model(mode[2], a_w[2], b_w[2]);

    gate_exerciser u_def (
        .clk(clk), .reset(reset), .start(start[0]),
        .a_out(a_w[0]), .b_out(b_w[0]), .s_in(s_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_vec(fail_w[0])
    );

    gate_exerciser #(.PASSES(4)) u_p4 (
        .clk(clk), .reset(reset), .start(start[1]),
        .a_out(a_w[1]), .b_out(b_w[1]), .s_in(s_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_vec(fail_w[1])
    );

    gate_exerciser #(.SETTLE(0)) u_s0 (
        .clk(clk), .reset(reset), .start(start[2]),
        .a_out(a_w[2]), .b_out(b_w[2]), .s_in(s_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .fail_vec(fail_w[2])
    );

    // cycle 0 is the cycle start is sampled in; lat is the done cycle index
    task automatic run(input int d, input bit hold, output int lat);
        lat = 0;
        @(negedge clk);
        start[d] = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (!hold)
                start[d] = 1'b0;
            trace[k] = {a_w[d], b_w[d]};
            if (done_w[d]) begin
                lat = k;
                break;
            end
        end
        start[d] = 1'b0;
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL run_timeout dut%0d: no done within 200 cycles", d);
        end
    endtask

    task automatic check_result(input int d, input string nm, input int lat,
                                input int lat_exp, input logic pass_exp,
                                input logic [3:0] err_exp,
                                input logic [3:0] fail_exp);
        checks++;
        if (lat !== lat_exp) begin
            errors++;
            $display("FAIL %s_latency got %0d want %0d", nm, lat, lat_exp);
        end
        checks++;
        if (busy_w[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_in_done got %b want 1", nm, busy_w[d]);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done_w[d], busy_w[d]} !== 2'b00) begin
            errors++;
            $display("FAIL %s_after_done done,busy got %b want 00", nm,
                     {done_w[d], busy_w[d]});
        end
        checks++;
        if (pass_w[d] !== pass_exp) begin
            errors++;
            $display("FAIL %s_pass got %b want %b", nm, pass_w[d], pass_exp);
        end
        checks++;
        if (err_w[d] !== err_exp) begin
            errors++;
            $display("FAIL %s_err_count got %0d want %0d", nm, err_w[d], err_exp);
        end
        checks++;
        if (fail_w[d] !== fail_exp) begin
            errors++;
            $display("FAIL %s_fail_vec got %b want %b", nm, fail_w[d], fail_exp);
        end
        checks++;
        if ({a_w[d], b_w[d]} !== 2'b11) begin
            errors++;
            $display("FAIL %s_ab_hold got %b want 11", nm, {a_w[d], b_w[d]});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({a_w[d], b_w[d], busy_w[d], done_w[d], pass_w[d],
                 err_w[d], fail_w[d]} !== 13'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d got %b want 0", d,
                         {a_w[d], b_w[d], busy_w[d], done_w[d], pass_w[d],
                          err_w[d], fail_w[d]});
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_nand();
        int lat;
        mode[0] = 0;
        run(0, 1'b0, lat);
        check_result(0, "nand", lat, 13, 1'b1, 4'd0, 4'b0000);
    endtask

    task automatic test_and();
        int lat;
        mode[0] = 1;
        run(0, 1'b0, lat);
        check_result(0, "and", lat, 13, 1'b0, 4'd4, 4'b1111);
    endtask

    task automatic test_tied1();
        int lat;
        mode[0] = 2;
        run(0, 1'b0, lat);
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (trace[k] !== 2'((k - 1) / 3)) begin
                errors++;
                $display("FAIL tied1_vector cycle %0d got %b want %b", k,
                         trace[k], 2'((k - 1) / 3));
            end
        end
        check_result(0, "tied1", lat, 13, 1'b0, 4'd1, 4'b1000);
    endtask

    task automatic test_saturate();
        int lat;
        mode[1] = 1;
        run(1, 1'b0, lat);
        check_result(1, "sat", lat, 49, 1'b0, 4'd15, 4'b1111);
    endtask

    task automatic test_back_to_back();
        int lat;
        int extra;
        mode[2] = 0;
        run(2, 1'b1, lat);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (trace[k] !== 2'(k - 1)) begin
                errors++;
                $display("FAIL s0_vector cycle %0d got %b want %b", k,
                         trace[k], 2'(k - 1));
            end
        end
        check_result(2, "s0", lat, 5, 1'b1, 4'd0, 4'b0000);
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_w[2] || busy_w[2])
                extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL s0_single_run extra active cycles got %0d want 0", extra);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        int seen;
        mode[0] = 1;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if ({a_w[0], b_w[0], busy_w[0], err_w[0]} !== {2'b10, 1'b1, 4'd2}) begin
            errors++;
            $display("FAIL midrun_pre a,b,busy,err got %b want 1010010",
                     {a_w[0], b_w[0], busy_w[0], err_w[0]});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0],
             fail_w[0]} !== 13'd0) begin
            errors++;
            $display("FAIL midrun_reset got %b want 0",
                     {a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0],
                      err_w[0], fail_w[0]});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_w[0] || busy_w[0])
                seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrun_no_done active cycles got %0d want 0", seen);
        end
        mode[0] = 0;
        run(0, 1'b0, lat);
        check_result(0, "rerun", lat, 13, 1'b1, 4'd0, 4'b0000);
    endtask

    initial begin
        mode[0] = 0;
        mode[1] = 0;
        mode[2] = 0;
        test_reset();
        test_nand();
        test_and();
        test_tied1();
        test_saturate();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
